onehot_req_encoder: RTL
=======================

// Module: onehot_req_encoder
// PURPOSE
//  - Encodes a 4-bit request vector into a stream of 2-bit codes, one per set bit, in priority order.
//  - Uses the same code mapping as the 2:4 select decoder: bit0->2'b00, bit1->01, bit2->10, bit3->11.
//  - Sits on the ALU result/flag side. It collects function-unit request lines and serializes them
//    into codes for the writeback mux.
//  - Accepts multi-hot vectors: with several bits set, it emits one code per bit over several
//    cycles, under valid/ready flow control.
// PARAMETERS
//  PRIO_LSB   1   1: lowest set index is emitted first; 0: highest set index is emitted first
// PORTS
//  clk        in   1  single clock; all state changes on rising edge
//  rst_n      in   1  reset, asynchronous assert, active-low
//  in_valid   in   1  in_bits is offered this cycle
//  in_ready   out  1  block will accept in_bits this cycle
//  in_bits    in   4  request vector (one-hot or multi-hot)
//  out_valid  out  1  out_code is valid
//  out_ready  in   1  consumer takes out_code this cycle
//  out_code   out  2  encoded index of the current highest-priority pending bit
//  out_last   out  1  out_code is the final pending bit of the current vector
//  zero_err   out  1  one-cycle pulse: an all-zero vector was accepted
// BEHAVIOUR
//  - State: pending[3:0] register. IDLE when pending==0, DRAIN otherwise.
//    No other state register is used.
//  - Reset (rst_n=0, async):
//    - pending=0 and zero_err=0.
//    - Hence out_valid=0, out_last=0, out_code=2'b00, in_ready=1.
//    - Reset asserted mid-drain discards all remaining bits; no code is emitted for them.
//  - in_ready = (pending==0). It is a registered-state function only, with no path from out_ready.
//  - Accept: when in_valid & in_ready, pending <= in_bits at the clock edge.
//    - in_valid while in_ready=0 is ignored; the source must hold its data.
//  - Latency: a vector accepted at edge N drives out_valid=1 in the cycle after edge N.
//  - Output (combinational from pending):
//    - out_valid = |pending.
//    - out_code = priority-encode(pending) per PRIO_LSB.
//    - out_last = popcount(pending)==1.
//    - When pending==0: out_code=2'b00 and out_last=0.
//  - Handshake: on out_valid & out_ready, the bit for out_code is cleared in pending.
//    - With out_ready=0: pending, out_code and out_last hold stable; there is no timeout.
//  - Throughput: one code per cycle while out_ready=1.
//    - One bubble cycle follows the last handshake before a new vector is accepted.
//    - Accept and drain never occur in the same cycle.
//  - Zero input: in_valid & in_ready & in_bits==0 sets zero_err=1 for exactly the next cycle.
//    - pending stays 0, out_valid stays 0, in_ready stays 1.
//    - Back-to-back zero vectors give back-to-back pulses.
//  - Each cycle, drain clears at most one bit. All-ones 1111 drains in 4 handshakes:
//    - PRIO_LSB=1: codes 00, 01, 10, 11 (last on 11).
//    - PRIO_LSB=0: codes 11, 10, 01, 00 (last on 00).
// STRUCTURE
//  - Shared package (alu_pkg):
//    - ENC_IN_W=4, ENC_CODE_W=2.
//    - Code constants CODE_B0..CODE_B3 = 2'b00..2'b11, shared with the 2:4 select decoder.
//  - Sub-module prio_enc4 (combinational):
//    - Inputs: vec[3:0], PRIO_LSB.
//    - Outputs: code[1:0], any, single (popcount==1).
//    - Instantiated once on pending.
//  - Top level: pending register, accept/clear logic, zero_err flop.
// TESTING
//  1. Reset: hold rst_n=0 with random inputs
//     -> in_ready=1, out_valid=0, out_code=00, zero_err=0.
//     Release rst_n -> outputs unchanged.
//  2. Single bit: in_bits=0100, in_valid=1, out_ready=1
//     -> next cycle out_valid=1, out_code=10, out_last=1.
//     The cycle after -> out_valid=0, in_ready=1.
//  3. Multi-hot 1011 with out_ready=1, PRIO_LSB=1
//     -> codes 00, 01, 11 on consecutive cycles; out_last only with 11.
//     With PRIO_LSB=0 -> 11, 01, 00.
//  4. Backpressure: 0110 accepted, out_ready=0 for 5 cycles
//     -> out_code=01 held stable, in_ready=0, new in_valid ignored.
//     Raise out_ready -> 01 then 10.
//  5. Zero input: in_bits=0000 accepted
//     -> zero_err=1 for one cycle, out_valid never rises, in_ready stays 1.
//  6. Async reset mid-drain: 1111 accepted, after 2 handshakes pulse rst_n low mid-cycle
//     -> out_valid drops immediately, remaining codes never emitted, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU-side constants: encoder widths and select codes
// common to the 2:4 select decoder and the request encoder.
package alu_pkg;

  localparam int ENC_IN_W   = 4;
  localparam int ENC_CODE_W = 2;

  localparam logic [ENC_CODE_W-1:0] CODE_B0 = 2'b00;
  localparam logic [ENC_CODE_W-1:0] CODE_B1 = 2'b01;
  localparam logic [ENC_CODE_W-1:0] CODE_B2 = 2'b10;
  localparam logic [ENC_CODE_W-1:0] CODE_B3 = 2'b11;

  function automatic logic [ENC_CODE_W-1:0] idx2code(
    input int unsigned idx
  );
    logic [ENC_CODE_W-1:0] c;
    c = CODE_B0;
    unique case (idx)
      0: c = CODE_B0;
      1: c = CODE_B1;
      2: c = CODE_B2;
      3: c = CODE_B3;
      default: c = CODE_B0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] popcnt4(
    input logic [ENC_IN_W-1:0] v
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < ENC_IN_W; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// 4-input priority encoder with selectable direction;
// also flags any-set and exactly-one-set.
module prio_enc4
  import alu_pkg::*;
#(
  parameter bit PRIO_LSB = 1'b1
) (
  input  logic [ENC_IN_W-1:0]   vec,
  output logic [ENC_CODE_W-1:0] code,
  output logic                  any,
  output logic                  single
);

  always_comb begin
    code   = CODE_B0;
    any    = |vec;
    single = (popcnt4(vec) == 3'd1);
    // scan so that the winning index is written last
    if (PRIO_LSB) begin
      for (int i = ENC_IN_W - 1; i >= 0; i--) begin
        if (vec[i]) code = idx2code(i);
      end
    end else begin
      for (int i = 0; i < ENC_IN_W; i++) begin
        if (vec[i]) code = idx2code(i);
      end
    end
  end

endmodule

// File: rtl/onehot_req_encoder.sv
// Serializes a multi-hot request vector into one 2-bit
// code per set bit, under valid/ready flow control.
module onehot_req_encoder
  import alu_pkg::*;
#(
  parameter bit PRIO_LSB = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ENC_IN_W-1:0]   in_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ENC_CODE_W-1:0] out_code,
  output logic                  out_last,
  output logic                  zero_err
);

  logic [ENC_IN_W-1:0]   pending;
  logic [ENC_CODE_W-1:0] enc_code;
  logic                  enc_any;
  logic                  enc_single;
  logic                  acc;
  logic                  hs;

  prio_enc4 #(
    .PRIO_LSB (PRIO_LSB)
  ) u_enc (
    .vec    (pending),
    .code   (enc_code),
    .any    (enc_any),
    .single (enc_single)
  );

  assign in_ready  = ~enc_any;
  assign out_valid = enc_any;
  assign out_code  = enc_code;
  assign out_last  = enc_single;

  // accept only when empty, so accept and drain are exclusive
  assign acc = in_valid & in_ready;
  assign hs  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      zero_err <= 1'b0;
    end else begin
      zero_err <= acc & (in_bits == '0);
      if (acc) begin
        pending <= in_bits;
      end else if (hs) begin
        pending[enc_code] <= 1'b0;
      end
    end
  end

endmodule
